adc_frame_serializer: RTL and testbench

//  Upstream feeder of the pipe TX FIFO, in the PID clock domain. Latches the latest

---
 rtl/pipe_tx_pkg.sv | 27 ++
 rtl/frame_decimator.sv | 28 ++
 rtl/adc_frame_serializer.sv | 165 ++++++++++++++++
 tb/tb_adc_frame_serializer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_tx_pkg.sv
// Shared definitions for the pipe TX path: header layout, frame FSM encoding
// and the lowest-set-bit helper used to walk the channel enable mask.
package pipe_tx_pkg;

  localparam logic [7:0] HEADER_MARK = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_CHAN = 2'd2
  } state_t;

  function automatic logic [15:0] hdr_word(input logic [7:0] mark, input logic [7:0] cnt);
    return {mark, cnt};
  endfunction

  // Returns {found, index} of the lowest set bit of an 8-bit mask.
  function automatic logic [3:0] lowest_set(input logic [7:0] mask);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/frame_decimator.sv
// Counts ADC conversion cycles and fires a one-cycle frame trigger every
// max(decim_in,1) cycles; ">=" makes a lowered ratio take effect promptly.
module frame_decimator (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        cycle_done_in,
  input  logic [15:0] decim_in,
  output logic        trig_out
);

  logic [15:0] r_dcnt;
  logic [15:0] w_lim;
  logic        w_hit;

  assign w_lim    = (decim_in == 16'd0) ? 16'd0 : decim_in - 16'd1;
  assign w_hit    = (r_dcnt >= w_lim);
  assign trig_out = cycle_done_in & w_hit;

  // Decimation counter, advanced once per conversion cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_dcnt <= 16'd0;
    end else if (cycle_done_in) begin
      r_dcnt <= w_hit ? 16'd0 : r_dcnt + 16'd1;
    end
  end

endmodule

// File: rtl/adc_frame_serializer.sv
// Latches the latest sample per ADC channel and, on each decimated trigger,
// emits a header word plus the enabled channel samples one word per clock.
module adc_frame_serializer
  import pipe_tx_pkg::*;
#(
  parameter int         N_ADC       = 6,
  parameter logic [7:0] HEADER_MARK = pipe_tx_pkg::HEADER_MARK
) (
  input  logic                 pid_clk_in,
  input  logic                 rst_n_in,
  input  logic [N_ADC-1:0]     adc_dv_in,
  input  logic [16*N_ADC-1:0]  adc_data_in,
  input  logic                 cycle_done_in,
  input  logic [N_ADC-1:0]     chan_en_in,
  input  logic [15:0]          decim_in,
  input  logic                 clr_in,
  output logic                 data_valid_out,
  output logic [15:0]          data_out,
  output logic                 busy_out,
  output logic                 overrun_out
);

  logic [15:0]      r_hold [N_ADC];
  logic [15:0]      r_fbuf [N_ADC];
  logic [15:0]      w_snap [N_ADC];
  logic [N_ADC-1:0] r_en_q;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_frame_cnt, w_frame_cnt_nxt;
  state_t           r_state, w_state_nxt;
  logic             r_dv, w_dv_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_overrun, w_overrun_nxt;
  logic [15:0]      r_data, w_data_nxt;
  logic             w_trig, w_accept;
  logic [7:0]       w_en8;
  logic [3:0]       w_first, w_next;

  frame_decimator u_decim (
    .clk_in        (pid_clk_in),
    .rst_n_in      (rst_n_in),
    .cycle_done_in (cycle_done_in),
    .decim_in      (decim_in),
    .trig_out      (w_trig)
  );

  assign w_accept = w_trig && (r_state == ST_IDLE);
  assign w_en8    = 8'(r_en_q);
  assign w_first  = lowest_set(w_en8);
  assign w_next   = lowest_set(w_en8 & (8'hFE << r_idx));

  // Snapshot view: a sample arriving in the trigger cycle wins over the hold reg.
  always_comb begin
    for (int i = 0; i < N_ADC; i++) begin
      w_snap[i] = adc_dv_in[i] ? adc_data_in[16*i +: 16] : r_hold[i];
    end
  end

  // Per-channel hold registers, updated regardless of frame state.
  always_ff @(posedge pid_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < N_ADC; i++) r_hold[i] <= 16'd0;
    end else begin
      for (int i = 0; i < N_ADC; i++) begin
        if (adc_dv_in[i]) r_hold[i] <= adc_data_in[16*i +: 16];
      end
    end
  end

  // Frame buffer and enable mask captured once per accepted trigger.
  always_ff @(posedge pid_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < N_ADC; i++) r_fbuf[i] <= 16'd0;
      r_en_q <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < N_ADC; i++) r_fbuf[i] <= w_snap[i];
      r_en_q <= chan_en_in;
    end
  end

  // Next state and next registered outputs; outputs describe the word being emitted.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_frame_cnt_nxt = r_frame_cnt;
    w_dv_nxt        = 1'b0;
    w_busy_nxt      = 1'b0;
    w_data_nxt      = 16'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_HEAD;
          w_dv_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
          w_data_nxt  = hdr_word(HEADER_MARK, r_frame_cnt);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HEAD: begin
        w_frame_cnt_nxt = r_frame_cnt + 8'd1;
        if (w_first[3]) begin
          w_state_nxt = ST_CHAN;
          w_idx_nxt   = w_first[2:0];
          w_dv_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
          w_data_nxt  = r_fbuf[w_first[2:0]];
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CHAN: begin
        if (w_next[3]) begin
          w_idx_nxt  = w_next[2:0];
          w_dv_nxt   = 1'b1;
          w_busy_nxt = 1'b1;
          w_data_nxt = r_fbuf[w_next[2:0]];
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // A dropped trigger overrides a same-cycle clear.
  always_comb begin
    w_overrun_nxt = r_overrun;
    if (w_trig && r_busy) begin
      w_overrun_nxt = 1'b1;
    end else if (clr_in) begin
      w_overrun_nxt = 1'b0;
    end else begin
      w_overrun_nxt = r_overrun;
    end
  end

  // FSM state and output registers.
  always_ff @(posedge pid_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= ST_IDLE;
      r_idx       <= 3'd0;
      r_frame_cnt <= 8'd0;
      r_dv        <= 1'b0;
      r_busy      <= 1'b0;
      r_data      <= 16'd0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_dv        <= w_dv_nxt;
      r_busy      <= w_busy_nxt;
      r_data      <= w_data_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign data_valid_out = r_dv;
  assign data_out       = r_data;
  assign busy_out       = r_busy;
  assign overrun_out    = r_overrun;

endmodule

// File: tb/tb_adc_frame_serializer.sv
// Directed bench for adc_frame_serializer: inputs driven and outputs sampled on
// the falling edge, expected words hand-derived from the frame format.
module tb_adc_frame_serializer;

  localparam int N = 6;

  logic             pid_clk_in = 1'b0;
  logic             rst_n_in;
  logic [N-1:0]     adc_dv_in;
  logic [16*N-1:0]  adc_data_in;
  logic             cycle_done_in;
  logic [N-1:0]     chan_en_in;
  logic [15:0]      decim_in;
  logic             clr_in;
  logic             data_valid_out;
  logic [15:0]      data_out;
  logic             busy_out;
  logic             overrun_out;

  int n_cmp = 0;
  int n_err = 0;
  int hdr_n = 0;

  adc_frame_serializer #(.N_ADC(N), .HEADER_MARK(8'hA5)) dut (
    .pid_clk_in     (pid_clk_in),
    .rst_n_in       (rst_n_in),
    .adc_dv_in      (adc_dv_in),
    .adc_data_in    (adc_data_in),
    .cycle_done_in  (cycle_done_in),
    .chan_en_in     (chan_en_in),
    .decim_in       (decim_in),
    .clr_in         (clr_in),
    .data_valid_out (data_valid_out),
    .data_out       (data_out),
    .busy_out       (busy_out),
    .overrun_out    (overrun_out)
  );

  always #5 pid_clk_in = ~pid_clk_in;

  task automatic pulse_cd();
    cycle_done_in = 1'b1;
    @(negedge pid_clk_in);
    cycle_done_in = 1'b0;
  endtask

  task automatic load_samples();
    for (int i = 0; i < N; i++) adc_data_in[16*i +: 16] = 16'(16'h1000 + i);
    adc_dv_in = 6'h3F;
    @(negedge pid_clk_in);
    adc_dv_in = 6'h00;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    @(negedge pid_clk_in);
    n_cmp++;
    if (data_valid_out !== 1'b0 || data_out !== 16'h0000 || busy_out !== 1'b0 || overrun_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got dv=%b data=%h busy=%b ovr=%b, want 0 0000 0 0",
               data_valid_out, data_out, busy_out, overrun_out);
    end
    rst_n_in = 1'b1;
    @(negedge pid_clk_in);
  endtask

  task automatic test_full_frame();
    logic [15:0] exp;
    decim_in = 16'd1;
    chan_en_in = 6'h3F;
    load_samples();
    for (int f = 0; f < 2; f++) begin
      pulse_cd();
      for (int k = 0; k < 7; k++) begin
        exp = (k == 0) ? {8'hA5, 8'(hdr_n)} : 16'(16'h1000 + k - 1);
        n_cmp++;
        if (data_valid_out !== 1'b1 || busy_out !== 1'b1 || data_out !== exp) begin
          n_err++;
          $display("FAIL full_frame f%0d w%0d: got dv=%b busy=%b data=%h, want 1 1 %h",
                   f, k, data_valid_out, busy_out, data_out, exp);
        end
        @(negedge pid_clk_in);
      end
      n_cmp++;
      if (data_valid_out !== 1'b0 || busy_out !== 1'b0) begin
        n_err++;
        $display("FAIL full_frame_end f%0d: got dv=%b busy=%b, want 0 0", f, data_valid_out, busy_out);
      end
      hdr_n++;
    end
  endtask

  task automatic test_decim();
    logic exp_dv;
    decim_in = 16'd4;
    chan_en_in = 6'h00;
    for (int k = 1; k <= 8; k++) begin
      pulse_cd();
      exp_dv = (k % 4 == 0);
      n_cmp++;
      if (data_valid_out !== exp_dv || (exp_dv && data_out !== {8'hA5, 8'(hdr_n)})) begin
        n_err++;
        $display("FAIL decim pulse%0d: got dv=%b data=%h, want dv=%b data=%h",
                 k, data_valid_out, data_out, exp_dv, {8'hA5, 8'(hdr_n)});
      end
      if (exp_dv) hdr_n++;
      @(negedge pid_clk_in);
    end
    decim_in = 16'd0;
    pulse_cd();
    n_cmp++;
    if (data_valid_out !== 1'b1 || data_out !== {8'hA5, 8'(hdr_n)}) begin
      n_err++;
      $display("FAIL decim_zero: got dv=%b data=%h, want 1 %h", data_valid_out, data_out, {8'hA5, 8'(hdr_n)});
    end
    hdr_n++;
    @(negedge pid_clk_in);
    decim_in = 16'd1;
  endtask

  task automatic test_sparse();
    logic [15:0] ex [4];
    chan_en_in = 6'b100101;
    ex[0] = {8'hA5, 8'(hdr_n)};
    ex[1] = 16'h1000;
    ex[2] = 16'h1002;
    ex[3] = 16'h1005;
    pulse_cd();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (data_valid_out !== 1'b1 || busy_out !== 1'b1 || data_out !== ex[k]) begin
        n_err++;
        $display("FAIL sparse w%0d: got dv=%b busy=%b data=%h, want 1 1 %h",
                 k, data_valid_out, busy_out, data_out, ex[k]);
      end
      @(negedge pid_clk_in);
    end
    n_cmp++;
    if (data_valid_out !== 1'b0 || busy_out !== 1'b0) begin
      n_err++;
      $display("FAIL sparse_end: got dv=%b busy=%b, want 0 0", data_valid_out, busy_out);
    end
    hdr_n++;
    chan_en_in = 6'h00;
    pulse_cd();
    n_cmp++;
    if (data_valid_out !== 1'b1 || busy_out !== 1'b1 || data_out !== {8'hA5, 8'(hdr_n)}) begin
      n_err++;
      $display("FAIL header_only: got dv=%b busy=%b data=%h, want 1 1 %h",
               data_valid_out, busy_out, data_out, {8'hA5, 8'(hdr_n)});
    end
    hdr_n++;
    @(negedge pid_clk_in);
    n_cmp++;
    if (data_valid_out !== 1'b0 || busy_out !== 1'b0) begin
      n_err++;
      $display("FAIL header_only_end: got dv=%b busy=%b, want 0 0", data_valid_out, busy_out);
    end
  endtask

  task automatic test_overrun();
    chan_en_in = 6'h3F;
    pulse_cd();
    n_cmp++;
    if (data_out !== {8'hA5, 8'(hdr_n)} || overrun_out !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_head: got data=%h ovr=%b, want %h 0", data_out, overrun_out, {8'hA5, 8'(hdr_n)});
    end
    pulse_cd();
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (data_valid_out !== 1'b1 || data_out !== 16'(16'h1000 + k) || overrun_out !== 1'b1) begin
        n_err++;
        $display("FAIL ovr_chan%0d: got dv=%b data=%h ovr=%b, want 1 %h 1",
                 k, data_valid_out, data_out, overrun_out, 16'(16'h1000 + k));
      end
      @(negedge pid_clk_in);
    end
    n_cmp++;
    if (data_valid_out !== 1'b0 || busy_out !== 1'b0 || overrun_out !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_end: got dv=%b busy=%b ovr=%b, want 0 0 1", data_valid_out, busy_out, overrun_out);
    end
    hdr_n++;
    chan_en_in = 6'h00;
    pulse_cd();
    n_cmp++;
    if (busy_out !== 1'b1 || data_out !== {8'hA5, 8'(hdr_n)}) begin
      n_err++;
      $display("FAIL ovr_head2: got busy=%b data=%h, want 1 %h", busy_out, data_out, {8'hA5, 8'(hdr_n)});
    end
    hdr_n++;
    clr_in = 1'b1;
    pulse_cd();
    clr_in = 1'b0;
    n_cmp++;
    if (overrun_out !== 1'b1 || data_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_clr_and_drop: got ovr=%b dv=%b, want 1 0", overrun_out, data_valid_out);
    end
    clr_in = 1'b1;
    @(negedge pid_clk_in);
    clr_in = 1'b0;
    n_cmp++;
    if (overrun_out !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_clear: got ovr=%b, want 0", overrun_out);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] exp;
    chan_en_in = 6'h3F;
    adc_data_in[16*3 +: 16] = 16'hBEEF;
    adc_dv_in = 6'b001000;
    pulse_cd();
    adc_dv_in = 6'h00;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) exp = {8'hA5, 8'(hdr_n)};
      else if (k == 4) exp = 16'hBEEF;
      else exp = 16'(16'h1000 + k - 1);
      n_cmp++;
      if (data_valid_out !== 1'b1 || data_out !== exp) begin
        n_err++;
        $display("FAIL bypass w%0d: got dv=%b data=%h, want 1 %h", k, data_valid_out, data_out, exp);
      end
      @(negedge pid_clk_in);
    end
    hdr_n++;
  endtask

  task automatic test_reset_mid_frame();
    pulse_cd();
    n_cmp++;
    if (data_out !== {8'hA5, 8'(hdr_n)}) begin
      n_err++;
      $display("FAIL rst_pre_head: got data=%h, want %h", data_out, {8'hA5, 8'(hdr_n)});
    end
    @(negedge pid_clk_in);
    rst_n_in = 1'b0;
    #1;
    n_cmp++;
    if (data_valid_out !== 1'b0 || busy_out !== 1'b0 || data_out !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_async: got dv=%b busy=%b data=%h, want 0 0 0000", data_valid_out, busy_out, data_out);
    end
    @(negedge pid_clk_in);
    rst_n_in = 1'b1;
    hdr_n = 0;
    chan_en_in = 6'h01;
    pulse_cd();
    n_cmp++;
    if (data_valid_out !== 1'b1 || data_out !== 16'hA500) begin
      n_err++;
      $display("FAIL rst_first_head: got dv=%b data=%h, want 1 A500", data_valid_out, data_out);
    end
    @(negedge pid_clk_in);
    n_cmp++;
    if (data_valid_out !== 1'b1 || data_out !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_hold_cleared: got dv=%b data=%h, want 1 0000", data_valid_out, data_out);
    end
    @(negedge pid_clk_in);
    chan_en_in = 6'h00;
    for (int f = 1; f < 256; f++) begin
      pulse_cd();
      n_cmp++;
      if (data_out !== {8'hA5, 8'(f)}) begin
        n_err++;
        $display("FAIL wrap_seq f%0d: got data=%h, want %h", f, data_out, {8'hA5, 8'(f)});
      end
      @(negedge pid_clk_in);
    end
    pulse_cd();
    n_cmp++;
    if (data_valid_out !== 1'b1 || data_out !== 16'hA500) begin
      n_err++;
      $display("FAIL wrap: got dv=%b data=%h, want 1 A500", data_valid_out, data_out);
    end
    @(negedge pid_clk_in);
  endtask

  initial begin
    rst_n_in      = 1'b0;
    adc_dv_in     = '0;
    adc_data_in   = '0;
    cycle_done_in = 1'b0;
    chan_en_in    = '0;
    decim_in      = 16'd1;
    clr_in        = 1'b0;
    test_reset();
    test_full_frame();
    test_decim();
    test_sparse();
    test_overrun();
    test_bypass();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
